// File: rtl/io_loopback_selftest.sv
// IO loopback self-test controller.
// Drives a pattern onto the pins, waits SETTLE cycles, then compares the
// looped-back value. Walking-one, walking-zero, binary count and Galois LFSR
// patterns are supported. Results hold until the next accepted start.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pins released, waiting for start
// DRIVE | pattern(step) driven, settle counter running down
// CHECK | pattern still driven, pins_in compared against pattern(step)
// DONE  | one cycle, pass verdict latched, done pulse issued on exit
module io_loopback_selftest #(
    parameter int          WIDTH     = 8,
    parameter int          SETTLE    = 2,
    parameter logic [7:0]  LFSR_TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] TAPS        = LFSR_TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LAST_WALK   = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LAST_COUNT  = {WIDTH{1'b1}};
    // LFSR never reaches zero, so it visits 2^WIDTH-1 states.
    localparam logic [WIDTH-1:0] LAST_LFSR   = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] last_step;
    logic [WIDTH-1:0] pattern;
    logic             mismatch;
    logic             done_q;
    logic             pass_q;
    logic [7:0]       err_q;
    logic [WIDTH-1:0] ffi_q;

    // Pattern generation and end-of-sequence step for the latched mode.
    always_comb begin
        pattern   = '0;
        last_step = LAST_WALK;
        lfsr_next = {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
        case (mode_q)
            2'd0: begin
                pattern   = ONE << step;
                last_step = LAST_WALK;
            end
            2'd1: begin
                pattern   = ~(ONE << step);
                last_step = LAST_WALK;
            end
            2'd2: begin
                pattern   = step;
                last_step = LAST_COUNT;
            end
            default: begin
                pattern   = lfsr;
                last_step = LAST_LFSR;
            end
        endcase
        mismatch = (pins_in != pattern);
    end

    // State register; ena low freezes the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (settle_cnt == 4'd0) state_next = CHECK;
            CHECK:   state_next = (step == last_step) ? DONE : DRIVE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Step, pattern, settle timer and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 2'd0;
            step       <= '0;
            lfsr       <= '0;
            settle_cnt <= 4'd0;
            err_q      <= 8'd0;
            ffi_q      <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (ena) begin
            // done is issued on the edge that leaves DONE, alongside pass.
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        step       <= '0;
                        lfsr       <= ONE;
                        settle_cnt <= SETTLE_LOAD;
                        err_q      <= 8'd0;
                        ffi_q      <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        // err_q saturates, so zero reliably marks the first miss.
                        if (err_q == 8'd0) ffi_q <= step;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                    if (step != last_step) begin
                        step       <= step + ONE;
                        lfsr       <= lfsr_next;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    pass_q <= (err_q == 8'd0);
                end
                default: ;
            endcase
        end
    end

    // Pin drive and status outputs follow the state so reset releases pins at once.
    always_comb begin
        busy           = (state == DRIVE) || (state == CHECK);
        pins_oe        = busy ? '1 : '0;
        pins_out       = busy ? pattern : '0;
        done           = done_q;
        pass           = pass_q;
        err_count      = err_q;
        first_fail_idx = ffi_q;
    end

endmodule

// File: doc/io_loopback_selftest.md
IO_LOOPBACK_SELFTEST -- requirements
Module: io_loopback_selftest

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the pin count under test (2..8).
REQ-002 SHALL have parameter SETTLE, default 2, giving the drive-to-sample cycles (1..15).
REQ-003 SHALL have parameter LFSR_TAPS, default 8'hB8, giving the Galois LFSR feedback mask (low WIDTH bits used).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ena, input, 1; high enables the block, low freezes all state.
REQ-007 SHALL have port start, input, 1, a one-cycle test request.
REQ-008 SHALL have port mode, input, 2: 0 walking-one, 1 walking-zero, 2 binary count, 3 LFSR.
REQ-009 SHALL have port pins_in, input, WIDTH, the looped-back pin values.
REQ-010 SHALL have port pins_out, output, WIDTH, the driven pattern.
REQ-011 SHALL have port pins_oe, output, WIDTH, the per-pin output enable (1 = drive).
REQ-012 SHALL have port busy, output, 1, high while a test runs.
REQ-013 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-014 SHALL have port pass, output, 1; high when the last test had zero errors.
REQ-015 SHALL have port err_count, output, 8, the mismatch count.
REQ-016 SHALL have port first_fail_idx, output, WIDTH, the step index of the first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, CHECK and DONE.
REQ-018 In IDLE with ena=1 and start=1, SHALL latch mode, clear err_count, first_fail_idx and pass, set step=0, and enter DRIVE next cycle.
REQ-019 SHALL ignore start in any state other than IDLE; mode changes during a test have no effect.
REQ-020 SHALL stay in DRIVE exactly SETTLE cycles, then enter CHECK for exactly 1 cycle.
REQ-021 SHALL drive pins_oe all-ones in DRIVE and CHECK and all-zeros otherwise; pins_out is pattern(step) in DRIVE/CHECK and 0 otherwise.
REQ-022 SHALL use these patterns: walking-one 1<<step; walking-zero ~(1<<step); count step; LFSR seeded 1 at step 0, next = (s>>1) XOR (s[0] ? LFSR_TAPS : 0).
REQ-023 SHALL set the step count N to WIDTH for walking modes, 2^WIDTH for count and 2^WIDTH-1 for LFSR.
REQ-024 In CHECK, SHALL treat pins_in != pins_out as a mismatch: err_count increments, saturating at 255.
REQ-025 On the first mismatch only, SHALL set first_fail_idx=step.
REQ-026 After CHECK, if step==N-1 SHALL enter DONE; otherwise SHALL increment step and return to DRIVE.
REQ-027 DONE SHALL last 1 cycle: done=1, pass=(err_count==0) including any mismatch from the final CHECK, then IDLE.
REQ-028 pass, err_count and first_fail_idx SHALL hold until the next accepted start.
REQ-029 busy SHALL be 1 in DRIVE and CHECK, and 0 in IDLE and DONE.
REQ-030 Total latency SHALL be N*(SETTLE+1)+1 cycles from the start-sampling edge to the done-asserting edge.
REQ-031 With ena=0, all registers SHALL hold; the settle counter does not advance and outputs keep their values.

Reset
REQ-032 On rst=1, SHALL immediately (asynchronously) force IDLE, and pins_out, pins_oe, busy, done, pass, err_count, first_fail_idx and step to 0.
REQ-033 Reset mid-test SHALL abort the test with no done pulse; the next start after rst=0 runs a fresh test.

Verification
REQ-034 WIDTH=8, SETTLE=2, pins_in=pins_out, mode 0 -> pins_out 01,02,...,80; done 25 cycles after start; pass=1, err_count=0.
REQ-035 Bit 3 of pins_in stuck at 0, mode 0 -> err_count=1, first_fail_idx=3, pass=0.
REQ-036 Bit 0 of pins_in stuck at 1, mode 2 -> err_count=128, first_fail_idx=0, pass=0, done 769 cycles after start.
REQ-037 Loopback, mode 3 -> pins_out starts 01,B8,5C,...; 255 steps; pass=1.
REQ-038 rst pulsed at step 4 of mode 0 -> pins_oe=0 and busy=0 without waiting for a clock edge, no done pulse; a restart then passes.
REQ-039 ena=0 for 10 cycles mid-DRIVE plus start pulsed while busy -> state frozen, start ignored, done arrives 10 cycles late.
